// File: rtl/pwm_timing_pkg.sv
// Shared types and constants for the PWM edge calculator (pwm_timing_calc, pwm_edge_lane).
package pwm_timing_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PUBLISH = 2'd2} state_t;
  typedef enum logic {ALIGN_CENTER = 1'b0, ALIGN_LEFT = 1'b1} align_t;
  localparam int PIPE_STAGES = 4;
endpackage

// File: rtl/pwm_edge_lane.sv
// One edge lane: S1 phase offset, S2 pulse placement, S3 fold into [0, C); S4 is the staging write.
// PWM_DUTY_CLAMP_EN adds a duty clamp (D <= C) and a single phase wrap at S1.
module pwm_edge_lane
  import pwm_timing_pkg::*;
#(
  parameter int WIDTH = 13
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  align_t           i_align,
  input  logic [WIDTH-1:0] i_c,
  input  logic [WIDTH-1:0] i_d,
  input  logic [WIDTH-1:0] i_p,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall
);
  localparam int SW = WIDTH + 2;

  logic [WIDTH-1:0] w_d;
  logic [WIDTH-1:0] w_p;
`ifdef PWM_DUTY_CLAMP_EN
  assign w_d = (i_d > i_c) ? i_c : i_d;
  assign w_p = (i_p >= i_c) ? (i_p - i_c) : i_p;
`else
  assign w_d = i_d;
  assign w_p = i_p;
`endif

  logic                 r_v1, r_v2;
  align_t               r_a1;
  logic [WIDTH-1:0]     r_c1, r_d1, r_c2;
  logic signed [SW-1:0] r_p1, r_r2, r_f2;

  logic signed [SW-1:0] w_c_in, w_p_in, w_half, w_dful, w_odd, w_cs;
  logic [WIDTH-1:0]     w_rise, w_fall;

  assign w_c_in = {2'b00, i_c};
  assign w_p_in = {2'b00, w_p};
  assign w_half = {3'b000, r_d1[WIDTH-1:1]};
  assign w_dful = {2'b00, r_d1};
  assign w_odd  = {{(SW-1){1'b0}}, r_d1[0]};
  assign w_cs   = {2'b00, r_c2};

  // Single fold only: values more than one period out of range keep their modular low bits.
  always_comb begin
    w_rise = r_r2[WIDTH-1:0];
    w_fall = r_f2[WIDTH-1:0];
    if (r_r2[SW-1])        w_rise = WIDTH'(r_r2 + w_cs);
    else if (r_r2 >= w_cs) w_rise = WIDTH'(r_r2 - w_cs);
    if (r_f2 >= w_cs)      w_fall = WIDTH'(r_f2 - w_cs);
    if (r_c2 == '0) begin
      w_rise = '0;
      w_fall = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_v1    <= 1'b0;
      r_a1    <= ALIGN_CENTER;
      r_c1    <= '0;
      r_d1    <= '0;
      r_p1    <= '0;
      r_v2    <= 1'b0;
      r_c2    <= '0;
      r_r2    <= '0;
      r_f2    <= '0;
      o_valid <= 1'b0;
      o_rise  <= '0;
      o_fall  <= '0;
    end else begin
      r_v1    <= i_valid;
      r_a1    <= i_align;
      r_c1    <= i_c;
      r_d1    <= w_d;
      r_p1    <= w_c_in - w_p_in;
      r_v2    <= r_v1;
      r_c2    <= r_c1;
      if (r_a1 == ALIGN_LEFT) begin
        r_r2 <= r_p1;
        r_f2 <= r_p1 + w_dful;
      end else begin
        r_r2 <= r_p1 - w_half;
        r_f2 <= r_p1 + w_half + w_odd;
      end
      o_valid <= r_v2;
      o_rise  <= w_rise;
      o_fall  <= w_fall;
    end
  end
endmodule

// File: rtl/pwm_timing_calc.sv
// Per-channel PWM rise/fall edge calculator, LANES channels per clock, atomic publish of all edges.
// Optional build macro PWM_DUTY_CLAMP_EN (handled inside pwm_edge_lane) clamps duty and wraps phase.
module pwm_timing_calc
  import pwm_timing_pkg::*;
#(
  parameter int WIDTH = 13,
  parameter int DEPTH = 249,
  parameter int LANES = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_din_valid,
  input  logic             i_align,
  input  logic [WIDTH-1:0] i_cycle [DEPTH],
  input  logic [WIDTH-1:0] i_duty  [DEPTH],
  input  logic [WIDTH-1:0] i_phase [DEPTH],
  output logic             o_busy,
  output logic [WIDTH-1:0] o_rise  [DEPTH],
  output logic [WIDTH-1:0] o_fall  [DEPTH],
  output logic             o_dout_valid
);
  localparam int IW = $clog2(DEPTH + LANES) + 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WP = PIPE_STAGES - 1;
  localparam logic [IW-1:0] DEPTH_I = IW'(DEPTH);
  localparam logic [IW-1:0] LANES_I = IW'(LANES);

  state_t           r_state;
  logic             r_issue_done;
  logic [IW-1:0]    r_base;
  align_t           r_align;
  logic [WIDTH-1:0] r_duty       [DEPTH];
  logic [WIDTH-1:0] r_phase      [DEPTH];
  logic [WIDTH-1:0] r_stage_rise [DEPTH];
  logic [WIDTH-1:0] r_stage_fall [DEPTH];
  logic [AW-1:0]    r_wbase      [WP];
  logic             r_wlast      [WP];

  logic             w_issue, w_last_grp;
  logic             w_lane_vout [LANES];
  logic [WIDTH-1:0] w_lane_rise [LANES];
  logic [WIDTH-1:0] w_lane_fall [LANES];
  logic [AW-1:0]    w_wsel      [LANES];

  assign w_issue    = (r_state == RUN) && !r_issue_done;
  assign w_last_grp = (r_base + LANES_I) >= DEPTH_I;
  assign o_busy     = (r_state != IDLE);

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [IW-1:0] w_idx;
      logic          w_in_range;
      logic [AW-1:0] w_sel;

      // Lanes past DEPTH in the final group stay idle and never write.
      assign w_idx      = r_base + IW'(gi);
      assign w_in_range = w_idx < DEPTH_I;
      assign w_sel      = w_in_range ? w_idx[AW-1:0] : '0;
      assign w_wsel[gi] = r_wbase[WP-1] + AW'(gi);

      pwm_edge_lane #(.WIDTH(WIDTH)) u_lane (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (w_issue && w_in_range),
        .i_align (r_align),
        .i_c     (i_cycle[w_sel]),
        .i_d     (r_duty[w_sel]),
        .i_p     (r_phase[w_sel]),
        .o_valid (w_lane_vout[gi]),
        .o_rise  (w_lane_rise[gi]),
        .o_fall  (w_lane_fall[gi])
      );
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_issue_done <= 1'b0;
      r_base       <= '0;
      r_align      <= ALIGN_CENTER;
      o_dout_valid <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_duty[i]       <= '0;
        r_phase[i]      <= '0;
        r_stage_rise[i] <= '0;
        r_stage_fall[i] <= '0;
        o_rise[i]       <= '0;
        o_fall[i]       <= '0;
      end
      for (int s = 0; s < WP; s++) begin
        r_wbase[s] <= '0;
        r_wlast[s] <= 1'b0;
      end
    end else begin
      o_dout_valid <= 1'b0;
      // Group base index travels alongside the lane pipeline to address staging.
      r_wbase[0] <= AW'(r_base);
      r_wlast[0] <= w_issue && w_last_grp;
      for (int s = 1; s < WP; s++) begin
        r_wbase[s] <= r_wbase[s-1];
        r_wlast[s] <= r_wlast[s-1];
      end
      for (int l = 0; l < LANES; l++) begin
        if (w_lane_vout[l]) begin
          r_stage_rise[w_wsel[l]] <= w_lane_rise[l];
          r_stage_fall[w_wsel[l]] <= w_lane_fall[l];
        end
      end
      case (r_state)
        IDLE: begin
          if (i_din_valid) begin
            r_duty       <= i_duty;
            r_phase      <= i_phase;
            r_align      <= align_t'(i_align);
            r_base       <= '0;
            r_issue_done <= 1'b0;
            r_state      <= RUN;
          end
        end
        RUN: begin
          if (w_issue) begin
            if (w_last_grp) r_issue_done <= 1'b1;
            else            r_base       <= r_base + LANES_I;
          end
          if (r_wlast[WP-1]) r_state <= PUBLISH;
        end
        PUBLISH: begin
          o_rise       <= r_stage_rise;
          o_fall       <= r_stage_fall;
          o_dout_valid <= 1'b1;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pwm_timing_calc.sv
// Self-checking bench for pwm_timing_calc: directed and random runs against an integer edge model.
// Honours PWM_DUTY_CLAMP_EN in the model when the bundle is built with that macro.
module tb_pwm_timing_calc;
  localparam int WIDTH    = 13;
  localparam int DEPTH    = 249;
  localparam int LANES    = 4;
  localparam int G        = (DEPTH + LANES - 1) / LANES;
  localparam int LAT      = G + 5;
  localparam int MASK     = (1 << WIDTH) - 1;
  localparam int ABORT_AT = (G > 100) ? 100 : G / 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             din_valid = 1'b0;
  logic             align = 1'b0;
  logic [WIDTH-1:0] cycle [DEPTH];
  logic [WIDTH-1:0] duty  [DEPTH];
  logic [WIDTH-1:0] phase [DEPTH];
  logic             busy;
  logic             dout_valid;
  logic [WIDTH-1:0] rise  [DEPTH];
  logic [WIDTH-1:0] fall  [DEPTH];

  int exp_r [DEPTH];
  int exp_f [DEPTH];
  int n_checks = 0;
  int n_fail   = 0;
  int dv_count = 0;
  int run_id   = 0;

  pwm_timing_calc #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LANES(LANES)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_din_valid  (din_valid),
    .i_align      (align),
    .i_cycle      (cycle),
    .i_duty       (duty),
    .i_phase      (phase),
    .o_busy       (busy),
    .o_rise       (rise),
    .o_fall       (fall),
    .o_dout_valid (dout_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (dout_valid === 1'b1) dv_count++;

  task automatic check(input string tag, input int idx, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d]: observed %0d expected %0d", tag, idx, got, exp);
    end
  endtask

  // Edge placement from the arithmetic rules: offset by C-P, place the pulse, fold once.
  function automatic void model(input int c, input int d, input int p, input bit left,
                                output int r, output int f);
    int base;
    r = 0;
    f = 0;
    if (c == 0) return;
`ifdef PWM_DUTY_CLAMP_EN
    if (d > c) d = c;
    if (p >= c) p = p - c;
`endif
    base = c - p;
    if (left) begin
      r = base;
      f = base + d;
    end else begin
      r = base - d / 2;
      f = base + (d - d / 2);
    end
    if (r < 0) r = r + c;
    else if (r >= c) r = r - c;
    if (f >= c) f = f - c;
    r = r & MASK;
    f = f & MASK;
  endfunction

  task automatic fill(input int c, input int d, input int p);
    for (int i = 0; i < DEPTH; i++) begin
      cycle[i] = WIDTH'(c);
      duty[i]  = WIDTH'(d);
      phase[i] = WIDTH'(p);
    end
  endtask

  task automatic fill_random();
    int sel;
    for (int i = 0; i < DEPTH; i++) begin
      sel      = int'($urandom_range(0, 15));
      cycle[i] = (sel == 0) ? '0 : WIDTH'($urandom_range(1, MASK));
      duty[i]  = (sel == 1) ? '0 : WIDTH'($urandom_range(0, MASK));
      phase[i] = WIDTH'($urandom_range(0, MASK));
    end
  endtask

  // Start a run, scramble the captured inputs, then check latency, edges and the single pulse.
  task automatic do_run(input bit left, input bit second_strobe);
    int k;
    int dv0;
    for (int i = 0; i < DEPTH; i++) model(cycle[i], duty[i], phase[i], left, exp_r[i], exp_f[i]);
    dv0 = dv_count;
    run_id++;
    @(negedge clk);
    din_valid = 1'b1;
    align     = left;
    @(negedge clk);
    din_valid = 1'b0;
    k = 1;
    check("busy_after_start", run_id, busy, 1);
    for (int i = 0; i < DEPTH; i++) begin
      duty[i]  = WIDTH'($urandom_range(0, MASK));
      phase[i] = WIDTH'($urandom_range(0, MASK));
    end
    align = ~left;
    while (dout_valid !== 1'b1 && k < LAT + 20) begin
      @(negedge clk);
      k++;
      din_valid = second_strobe && (k == 10);
    end
    din_valid = 1'b0;
    $display("run %0d: align=%0d second_strobe=%0d dout_valid at cycle %0d", run_id, left, second_strobe, k);
    check("dout_valid_seen", run_id, dout_valid, 1);
    check("latency", run_id, k, LAT);
    check("busy_at_publish", run_id, busy, 0);
    for (int i = 0; i < DEPTH; i++) begin
      check("rise", i, rise[i], exp_r[i]);
      check("fall", i, fall[i], exp_f[i]);
    end
    @(negedge clk);
    check("dout_valid_one_cycle", run_id, dout_valid, 0);
    if (second_strobe) repeat (LAT + 5) @(negedge clk);
    check("dout_valid_pulses", run_id, dv_count - dv0, 1);
  endtask

  initial begin
    fill(0, 0, 0);
    #1;
    check("reset_busy", 0, busy, 0);
    check("reset_dout_valid", 0, dout_valid, 0);
    check("reset_rise", 0, rise[0], 0);
    check("reset_fall", DEPTH - 1, fall[DEPTH-1], 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    fill(4096, 2048, 0);
    do_run(1'b0, 1'b0);
    check("centre_rise_const", 0, rise[0], 3072);
    check("centre_fall_const", DEPTH - 1, fall[DEPTH-1], 1024);

    fill(1000, 900, 200);
    do_run(1'b1, 1'b0);
    check("left_rise_const", 7, rise[7], 800);
    check("left_fall_const", DEPTH - 1, fall[DEPTH-1], 700);

    fill(500, 800, 0);
    do_run(1'b0, 1'b0);
`ifdef PWM_DUTY_CLAMP_EN
    check("clamp_rise_const", 3, rise[3], 250);
    check("clamp_fall_const", 3, fall[3], 250);
`else
    check("modular_rise_const", 3, rise[3], 100);
    check("modular_fall_const", 3, fall[3], 400);
`endif

    for (int i = 0; i < DEPTH; i++) begin
      cycle[i] = WIDTH'($urandom_range(1, 1000));
      duty[i]  = WIDTH'(i);
      phase[i] = WIDTH'(3 * i);
    end
    do_run(1'b0, 1'b1);

    for (int n = 0; n < 4; n++) begin
      fill_random();
      do_run(n[0], 1'b0);
    end

    begin
      int dv0;
      fill_random();
      dv0 = dv_count;
      @(negedge clk);
      din_valid = 1'b1;
      @(negedge clk);
      din_valid = 1'b0;
      repeat (ABORT_AT - 1) @(negedge clk);
      rst_n = 1'b0;
      #1;
      $display("abort: reset asserted at cycle %0d of a run", ABORT_AT);
      check("abort_busy", 0, busy, 0);
      check("abort_dout_valid", 0, dout_valid, 0);
      for (int i = 0; i < DEPTH; i++) begin
        check("abort_rise", i, rise[i], 0);
        check("abort_fall", i, fall[i], 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (LAT + 10) @(negedge clk);
      check("abort_no_dout", 0, dv_count - dv0, 0);
    end

    fill_random();
    do_run(1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
